// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ssd_pkg;

  localparam int         NUM_CLIENTS = 4;
  localparam logic [3:0] BLANK_MODE  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/ssd_rr_pick.sv
// Round-robin pick: first set req bit scanning circularly from last+1.
module ssd_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Scan from the lowest-priority offset down so the nearest requester wins.
  always_comb begin
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of a shared 4-digit SSD with a minimum dwell per owner
// and a blanking gap between owners. All outputs are registered.
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int DWELL = 100000000,
  parameter int GAP   = 10000000,
  parameter int CNT_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic [3:0]  mode0,
  input  logic [3:0]  mode1,
  input  logic [3:0]  mode2,
  input  logic [3:0]  mode3,
  output logic [3:0]  grant,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  mode,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       grant_q, mode_q;
  logic [15:0]      dig_q;
  logic             busy_q;

  logic [NUM_CLIENTS-1:0][15:0] data_a;
  logic [NUM_CLIENTS-1:0][3:0]  mode_a;
  logic [1:0] winner;
  logic       any, take, drop, preempt;
  logic [3:0] owner_oh;

  assign data_a = {data3, data2, data1, data0};
  assign mode_a = {mode3, mode2, mode1, mode0};

  ssd_rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  // While owning, last_q is the current owner.
  assign owner_oh = 4'b0001 << last_q;
  assign drop     = ~req[last_q];
  assign preempt  = (cnt_q == DWELL_LAST) && |(req & ~owner_oh);
  assign take     = any && ((state_q == ST_IDLE) ||
                            (state_q == ST_GAP && cnt_q == GAP_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      dig_q   <= 16'h0000;
      mode_q  <= BLANK_MODE;
      busy_q  <= 1'b0;
    end else if (take) begin
      state_q <= ST_OWN;
      last_q  <= winner;
      cnt_q   <= '0;
      grant_q <= 4'b0001 << winner;
      dig_q   <= data_a[winner];
      mode_q  <= mode_a[winner];
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          grant_q <= 4'b0000;
          mode_q  <= BLANK_MODE;
          busy_q  <= 1'b0;
        end
        ST_OWN: begin
          if (drop || preempt) begin
            state_q <= ST_GAP;
            grant_q <= 4'b0000;
            mode_q  <= BLANK_MODE;
            cnt_q   <= '0;
          end else begin
            dig_q  <= data_a[last_q];
            mode_q <= mode_a[last_q];
            if (cnt_q != DWELL_LAST) cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 4'b0000;
          mode_q  <= BLANK_MODE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign digit0 = dig_q[3:0];
  assign digit1 = dig_q[7:4];
  assign digit2 = dig_q[11:8];
  assign digit3 = dig_q[15:12];
  assign mode   = mode_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Scoreboarded bench for ssd_display_arbiter with DWELL=8, GAP=2.
module tb_ssd_display_arbiter;

  localparam int DWELL = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic [3:0]  mode0, mode1, mode2, mode3;
  logic [3:0]  grant, digit0, digit1, digit2, digit3, mode;
  logic        busy;

  ssd_display_arbiter #(.DWELL(DWELL), .GAP(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .mode0(mode0), .mode1(mode1), .mode2(mode2), .mode3(mode3),
    .grant(grant), .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  grant;
    logic [15:0] dig;
    logic [3:0]  mode;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_st, m_last, m_cnt;   // 0 idle, 1 own, 2 gap
  exp_t m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_last = 3; m_cnt = 0; m_out = '0;
  endtask

  task automatic model_step();
    logic [15:0] d[4];
    logic [3:0]  md[4];
    int w;
    d  = '{data0, data1, data2, data3};
    md = '{mode0, mode1, mode2, mode3};
    w  = pick(req, m_last);
    if (w >= 0 && (m_st == 0 || (m_st == 2 && m_cnt == GAP - 1))) begin
      m_st = 1; m_last = w; m_cnt = 0;
      m_out.grant = 4'b0001 << w;
      m_out.dig   = d[w];
      m_out.mode  = md[w];
      m_out.busy  = 1'b1;
    end else if (m_st == 0) begin
      m_out.grant = 4'b0000; m_out.mode = 4'b0000; m_out.busy = 1'b0;
    end else if (m_st == 1) begin
      if (!req[m_last] || (m_cnt == DWELL - 1 && (req & ~(4'b0001 << m_last)) != 4'b0000)) begin
        m_st = 2; m_cnt = 0;
        m_out.grant = 4'b0000; m_out.mode = 4'b0000;
      end else begin
        m_out.dig  = d[m_last];
        m_out.mode = md[m_last];
        if (m_cnt < DWELL - 1) m_cnt++;
      end
    end else begin
      if (m_cnt == GAP - 1) begin
        m_st = 0; m_out.busy = 1'b0;
      end else m_cnt++;
    end
  endtask

  // Predict, push, clock, pop and compare.
  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("grant",  32'(grant), 32'(e.grant));
    chk("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e.dig));
    chk("mode",   32'(mode), 32'(e.mode));
    chk("busy",   32'(busy), 32'(e.busy));
  endtask

  // Called 1 time unit after a posedge; reset lands between edges.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_grant",  32'(grant), 32'h0);
    chk("rst_mode",   32'(mode), 32'h0);
    chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    model_reset();
    sb_q.delete();
    #2 rst = 1'b1;
  endtask

  function automatic logic [3:0] exp_rr(input int c);
    int idx;
    idx = c - 1;
    return ((idx % 10) < 8) ? (4'b0001 << ((idx / 10) % 4)) : 4'b0000;
  endfunction

  initial begin
    rst = 1'b0; req = 4'b0000;
    data0 = 16'h0123; data1 = 16'h4567; data2 = 16'h89AB; data3 = 16'hCDEF;
    mode0 = 4'hF; mode1 = 4'h7; mode2 = 4'h3; mode3 = 4'h1;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    // Round robin with everyone requesting
    req = 4'b1111;
    for (int c = 1; c <= 44; c++) begin
      cycle();
      chk("rr_grant", 32'(grant), 32'(exp_rr(c)));
    end
    apply_reset();
    cycle();
    chk("first_grant", 32'(grant), 32'h1);

    // Single request and live data reload
    apply_reset();
    req = 4'b0010; data1 = 16'h1234; mode1 = 4'hF;
    cycle();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_dig", 32'({digit3, digit2, digit1, digit0}), 32'h1234);
    chk("single_mode", 32'(mode), 32'hF);
    repeat (4) cycle();
    data1 = 16'hABCD;
    cycle();
    chk("live_dig", 32'({digit3, digit2, digit1, digit0}), 32'hABCD);

    // Early release by client 2 while client 0 waits
    apply_reset();
    req = 4'b0100;
    cycle();
    chk("er_grant", 32'(grant), 32'h4);
    req = 4'b0101;
    cycle(); cycle();
    chk("er_hold", 32'(grant), 32'h4);
    req = 4'b0001;
    cycle(); chk("er_gap0", 32'(grant), 32'h0);
    cycle(); chk("er_gap1", 32'(grant), 32'h0);
    cycle(); chk("er_next", 32'(grant), 32'h1);

    // No competitor: holds past dwell, then gap and idle
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      cycle();
      chk("nc_grant", 32'(grant), 32'h4);
    end
    req = 4'b0000;
    cycle(); chk("nc_gap_busy0", 32'(busy), 32'h1);
    cycle(); chk("nc_gap_busy1", 32'(busy), 32'h1);
    cycle(); chk("nc_idle_busy", 32'(busy), 32'h0);
    chk("nc_idle_grant", 32'(grant), 32'h0);

    // Owner drops on its dwell-expiry cycle while client 1 waits
    apply_reset();
    req = 4'b0011;
    for (int c = 0; c < DWELL; c++) begin
      cycle();
      chk("sim_own", 32'(grant), 32'h1);
    end
    req = 4'b0010;
    cycle(); chk("sim_gap0", 32'(grant), 32'h0);
    cycle(); chk("sim_gap1", 32'(grant), 32'h0);
    cycle(); chk("sim_next", 32'(grant), 32'h2);
    req = 4'b0000;
    cycle(); chk("gap_busy", 32'(busy), 32'h1);
    apply_reset();

    // Random traffic against the model
    req = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5, 0) == 0) begin
        int b;
        b = $urandom_range(3, 0);
        req[b] = ~req[b];
      end
      data0 = 16'($urandom); data1 = 16'($urandom);
      data2 = 16'($urandom); data3 = 16'($urandom);
      mode0 = 4'($urandom); mode1 = 4'($urandom);
      mode2 = 4'($urandom); mode3 = 4'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_display_arbiter.md
Name: ssd_display_arbiter

Overview:
- Shares one 4-digit seven-segment display between four requesting clients; drives the digit0..digit3 and mode inputs of the 4-digit SSD controller.
- Round-robin grant with a guaranteed minimum dwell time per owner, so each value stays readable.
- Blanking gap between owners.
- Sits between application blocks (counters, debug monitors, UART status) and the SSD controller.

Parameters:
- DWELL, 100000000: minimum ownership cycles before preemption (1 s at 100 MHz); must be ≥ 1.
- GAP, 10000000: blank cycles between owners (100 ms); must be ≥ 1.
- CNT_W, 27: width of the dwell/gap counter; must be ≥ clog2(max(DWELL, GAP) + 1).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- req  in  4  per-client display request; held high while the client wants the display
- data0  in  16  client 0 digits {d3,d2,d1,d0}; data1, data2, data3 are identical for clients 1-3
- mode0  in  4  client 0 digit-enable mask; mode1, mode2, mode3 are identical for clients 1-3
- grant  out  4  one-hot current owner; 0000 when none
- digit0, digit1, digit2, digit3  out  4 each  digits to the SSD controller
- mode  out  4  digit enables to the SSD controller; 0000 blanks the display
- busy  out  1  high in OWN and GAP states

Behaviour:
- All outputs are registered. Reset (rst low) asynchronously forces:
  - state IDLE, grant 0000, digits 0, mode 0000, busy 0;
  - last-owner pointer = 3, so client 0 has first priority;
  - counter 0.
- States:
  - IDLE: all outputs blank. If any req bit is set, pick the winner, then go to OWN.
  - OWN: the owner is fixed.
  - GAP: blank.
- Winner selection: first set req bit, scanning circularly from (last+1) mod 4.
- IDLE→OWN edge:
  - grant, digits and mode load the winner's data/mode on the same edge, visible the next cycle;
  - last-owner pointer := winner;
  - counter := 0.
- OWN, each cycle:
  - digit/mode registers reload the owner's live data/mode (1-cycle latency);
  - counter increments, saturating at DWELL-1.
- OWN→GAP when either:
  - req[owner] == 0: immediate release, dwell is not enforced; or
  - counter == DWELL-1 and any other req bit is set: preemption, so the owner is held exactly DWELL cycles.
- Single requester with no competitors: stays in OWN indefinitely.
- GAP entry:
  - grant := 0000, mode := 0000; digits keep their last values; counter := 0.
- GAP, each cycle: the counter increments. When counter == GAP-1:
  - if any req bit is set, arbitrate from the pointer (as IDLE→OWN) directly into OWN;
  - otherwise go to IDLE.
- Simultaneous owner-drop and dwell expiry: treated as a release; same GAP path.
- A client that drops req during GAP or IDLE is never granted.
- A re-requesting previous owner is served only after the clients following it.
- busy = 1 in OWN and GAP; 0 in IDLE.
- grant is always one-hot or zero.
- An illegal state encoding recovers to IDLE.

Decomposition:
- Package ssd_pkg:
  - state encoding constants IDLE / OWN / GAP (2 bits);
  - NUM_CLIENTS = 4;
  - BLANK_MODE = 4'b0000.
- Sub-module ssd_rr_pick: combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: winner[1:0] and any.
  - Rotate-and-priority-encode.
  - Verified standalone and exhaustively (64 cases).
- Top level holds the FSM, counter and output registers.

Test Plan (DWELL=8, GAP=2):
- Reset: drive rst=0 mid-stream with req=1111 → grant=0000, mode=0000, digits=0, busy=0 immediately (asynchronous). Release → first grant is client 0.
- Single request:
  - req=0010, data1=16'h1234, mode1=4'hF at cycle t → grant=0010, digit3..0 = 1,2,3,4, mode=F at t+1.
  - data1 → 16'hABCD at t+5 → outputs show A,B,C,D at t+6.
- Round robin: req=1111 held constant → grants 0001, 0010, 0100, 1000, 0001 in turn. Each owner lasts exactly 8 cycles, with exactly 2 cycles of grant=0000 and mode=0000 between owners.
- Early release: client 2 owns, drops req after 3 cycles while req0=1 → GAP after 3 owned cycles, then grant=0001 (not dwell-limited).
- No competitor: req=0100 only, held 50 cycles → grant stays 0100 for all 50 cycles. Drop req → 2-cycle GAP, then IDLE, busy=0.
- Simultaneous events: owner drops req on its dwell-expiry cycle while another client requests → single GAP of 2 cycles, next client granted. Reset mid-GAP → IDLE immediately.
